// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control-unit constants: address width, next-address selects, boot FSM states
package ctrl_pkg;

  localparam int AW_DEFAULT = 6;

  // Next-address select encodings driven by next_state_add_sel
  localparam logic [2:0] SEL_ENC  = 3'b000;
  localparam logic [2:0] SEL_ZERO = 3'b001;
  localparam logic [2:0] SEL_PIPE = 3'b010;
  localparam logic [2:0] SEL_INC  = 3'b011;
  localparam logic [2:0] SEL_PAST = 3'b100;

  // BOOT spends exactly one edge after reset; RUN is terminal until reset
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } boot_state_e;

endpackage

// File: rtl/next_addr_mux.sv
// rtl/next_addr_mux.sv - combinational 5:1 next microstore address select with illegal flag
module next_addr_mux
  import ctrl_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic [2:0]    sel_i,
  input  logic [AW-1:0] enc_i,
  input  logic [AW-1:0] pipe_i,
  input  logic [AW-1:0] inc_i,
  input  logic [AW-1:0] past_i,
  input  logic [AW-1:0] cur_i,
  output logic [AW-1:0] next_o,
  output logic          illegal_o
);

  // Unlisted or unknown selects self-loop on the current address and raise illegal
  always_comb begin
    next_o    = cur_i;
    illegal_o = 1'b0;
    case (sel_i)
      SEL_ENC:  next_o = enc_i;
      SEL_ZERO: next_o = '0;
      SEL_PIPE: next_o = pipe_i;
      SEL_INC:  next_o = inc_i;
      SEL_PAST: next_o = past_i;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/microseq_addr_reg.sv
// rtl/microseq_addr_reg.sv - microprogram address register with registered incrementer, past-state and boot FSM
module microseq_addr_reg
  import ctrl_pkg::*;
#(
  parameter int            AW          = AW_DEFAULT,
  parameter logic [AW-1:0] RESET_STATE = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [2:0]    M,
  input  logic [AW-1:0] EncAddr,
  input  logic [AW-1:0] PipeAddr,
  input  logic          Hold,
  output logic [AW-1:0] State,
  output logic [AW-1:0] IncAddr,
  output logic [AW-1:0] PastAddr,
  output logic          Valid,
  output logic          BadSel
);

  localparam logic [AW-1:0] RESET_INC = RESET_STATE + 1'b1;

  boot_state_e   fsm_q, fsm_d;
  logic [AW-1:0] state_q, state_d;
  logic [AW-1:0] inc_q, inc_d;
  logic [AW-1:0] past_q, past_d;
  logic          bad_q, bad_d;
  logic [AW-1:0] next_addr;
  logic          next_illegal;

  next_addr_mux #(
    .AW(AW)
  ) u_next_addr_mux (
    .sel_i    (M),
    .enc_i    (EncAddr),
    .pipe_i   (PipeAddr),
    .inc_i    (inc_q),
    .past_i   (past_q),
    .cur_i    (state_q),
    .next_o   (next_addr),
    .illegal_o(next_illegal)
  );

  // Boot step and RUN-mode advance; Hold freezes everything (including BadSel) only in RUN
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    inc_d   = inc_q;
    past_d  = past_q;
    bad_d   = bad_q;
    case (fsm_q)
      BOOT: fsm_d = RUN;
      RUN: begin
        if (!Hold) begin
          state_d = next_addr;
          inc_d   = next_addr + 1'b1;
          past_d  = state_q;
          bad_d   = bad_q | next_illegal;
        end
      end
    endcase
  end

  // All state registers; reset forces the fetch-entry address immediately
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsm_q   <= BOOT;
      state_q <= RESET_STATE;
      inc_q   <= RESET_INC;
      past_q  <= RESET_STATE;
      bad_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      inc_q   <= inc_d;
      past_q  <= past_d;
      bad_q   <= bad_d;
    end
  end

  assign State    = state_q;
  assign IncAddr  = inc_q;
  assign PastAddr = past_q;
  assign Valid    = (fsm_q == RUN);
  assign BadSel   = bad_q;

endmodule
